msk_romulus_seq: RTL

MSK_ROMULUS_SEQ -- requirements
Module: msk_romulus_seq

---
 rtl/msk_romulus_pkg.sv | 18 +
 rtl/msk_romulus_lfsr.sv | 22 ++
 rtl/msk_romulus_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/msk_romulus_pkg.sv
// Shared types and constants for the masked Romulus mode-level blocks.
package msk_romulus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [55:0] LFSR_POLY = 56'h95;
  localparam logic [55:0] LFSR_INIT = 56'h1;

  function automatic logic [55:0] lfsr_step(input logic [55:0] v);
    return {v[54:0], 1'b0} ^ (v[55] ? LFSR_POLY : 56'h0);
  endfunction

endpackage

// File: rtl/msk_romulus_lfsr.sv
// 56-bit block counter LFSR for the TK1 field; reload takes priority over step.
module msk_romulus_lfsr
  import msk_romulus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic        reload,
  output logic [55:0] value
);

  logic [55:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      lfsr_q <= LFSR_INIT;
    else if (reload) lfsr_q <= LFSR_INIT;
    else if (step)   lfsr_q <= lfsr_step(lfsr_q);
  end

  assign value = lfsr_q;

endmodule

// File: rtl/msk_romulus_seq.sv
// Block sequencer: accepts one shared block, runs it through the masked Skinny core,
// and holds the shared ciphertext until the consumer takes it.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | ready for a block; inputs registered on handshake
// ST_ISSUE | one-cycle core_start
// ST_WAIT  | waiting for core_done, no time limit
// ST_HOLD  | out_valid high until out_ready
module msk_romulus_seq
  import msk_romulus_pkg::*;
#(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic             blk_last,
  input  logic [7:0]       blk_domain,
  input  logic [128*d-1:0] blk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*d-1:0] out_data,
  output logic             core_start,
  output logic             core_last,
  input  logic             core_done,
  output logic [127:0]     core_tk1,
  output logic [128*d-1:0] core_pt,
  input  logic [128*d-1:0] core_ct,
  output logic             busy
);

  state_t state, state_nxt;

  logic [128*d-1:0] pt_q;
  logic [128*d-1:0] ct_q;
  logic [7:0]       dom_q;
  logic             last_q;
  logic [55:0]      lfsr;

  logic blk_accept, core_capture, out_hs;

  assign blk_accept   = (state == ST_IDLE) && blk_valid;
  assign core_capture = (state == ST_WAIT) && core_done;
  assign out_hs       = (state == ST_HOLD) && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    blk_ready  = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        blk_ready = 1'b1;
        busy      = 1'b0;
        if (blk_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        core_start = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shares are only ever moved whole; nothing combines one share with another.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pt_q   <= '0;
      ct_q   <= '0;
      dom_q  <= 8'h0;
      last_q <= 1'b0;
    end else begin
      if (blk_accept) begin
        pt_q   <= blk_data;
        dom_q  <= blk_domain;
        last_q <= blk_last;
      end
      if (core_capture) ct_q <= core_ct;
    end
  end

  msk_romulus_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .step   (out_hs && !last_q),
    .reload (out_hs && last_q),
    .value  (lfsr)
  );

  assign core_tk1  = {lfsr, dom_q, 64'h0};
  assign core_pt   = pt_q;
  assign core_last = last_q;
  assign out_data  = ct_q;

endmodule
